// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the board matrix and the lock datapath.
// The master side is the scanner; the slave side is the board/consumer.
interface keypad_scanner_if;
   logic [3:0] i_rows;
   logic [3:0] o_cols;
   logic [3:0] o_digit;
   logic       o_digit_valid;
   logic       o_confirm;
   logic       o_clear;
   logic [3:0] o_key_code;
   logic       o_key_held;

   modport master (
      input  i_rows,
      output o_cols, o_digit, o_digit_valid, o_confirm,
      output o_clear, o_key_code, o_key_held
   );

   modport slave (
      output i_rows,
      input  o_cols, o_digit, o_digit_valid, o_confirm,
      input  o_clear, o_key_code, o_key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Emits one-cycle digit / confirm / clear pulses per accepted key.
module keypad_scanner #(
   parameter int CLK_IN         = 50_000_000,
   parameter int SCAN_HZ        = 1_000,
   parameter int DEBOUNCE_TICKS = 4
) (
   input logic              i_clk,
   input logic              i_reset,
   keypad_scanner_if.master kp
);
   localparam int TICK_DIV = CLK_IN / SCAN_HZ;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_TICKS);
   // nibble {r,c} of this word is the key code at row r, column c
   localparam logic [63:0] KEY_LUT = 64'hDF0E_C987_B654_A321;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   state_t        state, state_nx;
   logic [3:0]    rows_m, rows_s;
   logic [TW-1:0] tcnt;
   logic          tick;
   logic [CW-1:0] cnt, cnt_nx, rcnt, rcnt_nx;
   logic [1:0]    row, row_nx, row_low, col;
   logic [3:0]    cols, cols_nx, cols_rot;
   logic          any_low, accept, release_key;
   logic [3:0]    code;
   logic          digit_nx, confirm_nx, clear_nx;

   assign tick     = (tcnt == TW'(TICK_DIV - 1));
   assign any_low  = ~&rows_s;
   assign cols_rot = {cols[2:0], cols[3]};
   assign kp.o_cols = cols;

   always_comb begin
      row_low = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (!rows_s[i]) row_low = 2'(i);
   end

   always_comb begin
      case (cols)
         4'b1101: col = 2'd1;
         4'b1011: col = 2'd2;
         4'b0111: col = 2'd3;
         default: col = 2'd0;
      endcase
   end

   // with a single-tick debounce the key is accepted straight from SCAN
   always_comb begin
      logic [1:0] r;
      r    = (state == SCAN) ? row_low : row;
      code = KEY_LUT[{r, col, 2'b00} +: 4];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rows_m <= 4'h0;
         rows_s <= 4'h0;
         tcnt   <= '0;
         state  <= SCAN;
         cnt    <= '0;
         rcnt   <= '0;
         row    <= 2'd0;
         cols   <= 4'b1110;
      end else begin
         rows_m <= kp.i_rows;
         rows_s <= rows_m;
         tcnt   <= tick ? '0 : tcnt + TW'(1);
         state  <= state_nx;
         cnt    <= cnt_nx;
         rcnt   <= rcnt_nx;
         row    <= row_nx;
         cols   <= cols_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      rcnt_nx     = rcnt;
      row_nx      = row;
      cols_nx     = cols;
      accept      = 1'b0;
      release_key = 1'b0;
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (any_low) begin
                  row_nx = row_low;
                  cnt_nx = CW'(1);
                  if (cnt_nx == CMAX) begin
                     accept   = 1'b1;
                     rcnt_nx  = '0;
                     state_nx = HELD;
                  end else begin
                     state_nx = DEBOUNCE;
                  end
               end else begin
                  cols_nx = cols_rot;
               end
            end
            DEBOUNCE: begin
               if (!rows_s[row]) begin
                  cnt_nx = (cnt == CMAX) ? cnt : cnt + CW'(1);
                  if (cnt_nx == CMAX) begin
                     accept   = 1'b1;
                     rcnt_nx  = '0;
                     state_nx = HELD;
                  end
               end else begin
                  cnt_nx   = '0;
                  cols_nx  = cols_rot;
                  state_nx = SCAN;
               end
            end
            HELD: begin
               if (any_low) rcnt_nx = '0;
               else rcnt_nx = (rcnt == CMAX) ? rcnt : rcnt + CW'(1);
               if (rcnt_nx == CMAX) begin
                  release_key = 1'b1;
                  cols_nx     = cols_rot;
                  state_nx    = SCAN;
               end
            end
            default: state_nx = SCAN;
         endcase
      end
   end

   always_comb begin
      digit_nx   = accept && (code < 4'd10);
      confirm_nx = accept && (code == 4'd15);
      clear_nx   = accept && (code == 4'd14);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         kp.o_digit       <= 4'd0;
         kp.o_digit_valid <= 1'b0;
         kp.o_confirm     <= 1'b0;
         kp.o_clear       <= 1'b0;
         kp.o_key_code    <= 4'd0;
         kp.o_key_held    <= 1'b0;
      end else begin
         kp.o_digit_valid <= digit_nx;
         kp.o_confirm     <= confirm_nx;
         kp.o_clear       <= clear_nx;
         if (accept) begin
            kp.o_key_code <= code;
            kp.o_key_held <= 1'b1;
            if (digit_nx) kp.o_digit <= code;
         end else if (release_key) begin
            kp.o_key_held <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, expected-event scoreboard,
// and a monitor that checks every accepted key the scanner reports.
module tb_keypad_scanner;
   typedef struct {
      logic [3:0] code;
      logic [2:0] pulses;
      logic [3:0] digit;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [15:0] pressed;
   logic [3:0]  rows_model;
   int          checks;
   int          errors;
   int          last_digit;
   exp_t        sbq[$];
   int          codes[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   keypad_scanner_if kp();

   keypad_scanner #(
      .CLK_IN(8),
      .SCAN_HZ(1),
      .DEBOUNCE_TICKS(3)
   ) dut (
      .i_clk(clk),
      .i_reset(rst),
      .kp(kp)
   );

   always #5 clk = ~clk;

   // key (r,c) shorts row r to column c; rows are pulled high otherwise
   always_comb begin
      rows_model = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !kp.o_cols[c]) rows_model[r] = 1'b0;
   end
   assign kp.i_rows = rows_model;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_key(input int k);
      exp_t e;
      int   c;
      c = codes[k];
      e.code = 4'(c);
      if (c < 10) begin
         e.pulses   = 3'b100;
         last_digit = c;
      end else if (c == 15) e.pulses = 3'b010;
      else if (c == 14) e.pulses = 3'b001;
      else e.pulses = 3'b000;
      e.digit = 4'(last_digit);
      sbq.push_back(e);
   endtask

   task automatic press_long(input int k);
      expect_key(k);
      pressed[k] = 1'b1;
      repeat (96) @(negedge clk);
      chk("held_during_press", 32'(kp.o_key_held), 1);
      pressed = '0;
      repeat (12) @(negedge clk);
      chk("held_after_release", 32'(kp.o_key_held), 1);
      repeat (28) @(negedge clk);
      chk("released", 32'(kp.o_key_held), 0);
      repeat (16) @(negedge clk);
   endtask

   task automatic bounce(input int k, input int len);
      pressed[k] = 1'b1;
      repeat (len) @(negedge clk);
      pressed = '0;
      repeat (48) @(negedge clk);
      chk("bounce_no_hold", 32'(kp.o_key_held), 0);
   endtask

   // monitor: every rising key_held is one accepted key
   always begin
      logic       prev_held;
      logic [2:0] pl;
      exp_t       e;
      prev_held = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         pl = {kp.o_digit_valid, kp.o_confirm, kp.o_clear};
         if (kp.o_key_held && !prev_held) begin
            if (sbq.size() == 0) begin
               chk("unexpected_accept", 32'(kp.o_key_code), 32'hFFFF);
            end else begin
               e = sbq.pop_front();
               chk("key_code", 32'(kp.o_key_code), 32'(e.code));
               chk("pulses", 32'(pl), 32'(e.pulses));
               chk("digit", 32'(kp.o_digit), 32'(e.digit));
            end
         end else begin
            chk("stray_pulse", 32'(pl), 0);
         end
         prev_held = kp.o_key_held;
      end
   end

   initial begin
      logic [3:0] ec;
      clk        = 1'b0;
      rst        = 1'b1;
      pressed    = '0;
      checks     = 0;
      errors     = 0;
      last_digit = 0;
      repeat (3) @(negedge clk);
      chk("rst_cols", 32'(kp.o_cols), 32'h0E);
      chk("rst_digit", 32'(kp.o_digit), 0);
      chk("rst_code", 32'(kp.o_key_code), 0);
      chk("rst_held", 32'(kp.o_key_held), 0);
      chk("rst_pulses", 32'({kp.o_digit_valid, kp.o_confirm, kp.o_clear}), 0);
      rst = 1'b0;

      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         ec = ~(4'(1) << ((n / 8) % 4));
         chk("idle_cols", 32'(kp.o_cols), 32'(ec));
      end
      @(negedge clk);

      press_long(5);
      press_long(14);
      press_long(12);
      bounce(9, 16);

      // keys 1 and 7 share column 0; then 9 pressed while held
      expect_key(0);
      pressed = 16'h0101;
      repeat (96) @(negedge clk);
      pressed[10] = 1'b1;
      repeat (40) @(negedge clk);
      chk("multi_held", 32'(kp.o_key_held), 1);
      pressed = '0;
      repeat (56) @(negedge clk);
      chk("multi_released", 32'(kp.o_key_held), 0);

      // reset while 'A' is held
      expect_key(3);
      pressed[3] = 1'b1;
      for (int i = 0; i < 200 && !kp.o_key_held; i++) @(negedge clk);
      chk("a_held", 32'(kp.o_key_held), 1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_held", 32'(kp.o_key_held), 0);
      chk("mid_rst_code", 32'(kp.o_key_code), 0);
      chk("mid_rst_cols", 32'(kp.o_cols), 32'h0E);
      pressed    = '0;
      last_digit = 0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (80) @(negedge clk);
      chk("post_rst_held", 32'(kp.o_key_held), 0);

      for (int it = 0; it < 24; it++) begin
         int k;
         k = int'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) bounce(k, int'($urandom_range(1, 15)));
         else press_long(k);
      end

      repeat (20) @(negedge clk);
      chk("queue_empty", 32'(sbq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
